// File: rtl/neopix_pkg.sv
// neopix_pkg: shared definitions for the WS2812 frame serializer.
//   state_e         : serializer FSM states.
//   cycles_from_ns  : converts a duration in ns to clk cycles (truncating).
//   DEF_*           : default timing constants.
package neopix_pkg;

  typedef enum logic [1:0] {
    LATCH = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_e;

  localparam int DEF_NUM_LEDS     = 8;
  localparam int DEF_SYSTEM_CLOCK = 50_000_000;
  localparam int DEF_T0H_NS       = 400;
  localparam int DEF_T1H_NS       = 800;
  localparam int DEF_BIT_NS       = 1250;
  localparam int DEF_RESET_US     = 60;
  localparam int DEF_RD_LATENCY   = 2;

  // Divide the clock down to MHz first so the product stays inside 32 bits.
  function automatic int cycles_from_ns(input int clk_hz, input int ns);
    return clk_hz / 1000000 * ns / 1000;
  endfunction

endpackage

// File: rtl/neopix_frame_serializer_bit_timer.sv
// neopix_bit_timer: generates the NRZ waveform of one WS2812 bit.
//   clk, rst  : clock, asynchronous active-high reset.
//   start     : pulse; the bit begins (phase 0) on the following cycle.
//   bit_val   : value of the bit being sent; must be stable for the bit.
//   do_out    : line level, high while phase < (bit_val ? T1H : T0H).
//   bit_done  : high during the last phase (BIT-1) of the bit.
module neopix_bit_timer
  import neopix_pkg::*;
#(
  parameter int T0H = 20,
  parameter int T1H = 40,
  parameter int BIT = 62
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_val,
  output logic do_out,
  output logic bit_done
);

  localparam int PW = (BIT > 1) ? $clog2(BIT) : 1;
  localparam logic [PW-1:0] T0H_P  = PW'(T0H);
  localparam logic [PW-1:0] T1H_P  = PW'(T1H);
  localparam logic [PW-1:0] LAST_P = PW'(BIT - 1);

  logic          active_q, active_d;
  logic [PW-1:0] phase_q, phase_d;

  always_comb begin
    active_d = active_q;
    phase_d  = phase_q;
    bit_done = active_q && (phase_q == LAST_P);
    // A start on the bit_done cycle chains the next bit with no idle cycle.
    if (start) begin
      active_d = 1'b1;
      phase_d  = '0;
    end else if (active_q) begin
      if (bit_done) begin
        active_d = 1'b0;
        phase_d  = '0;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
    do_out = active_q && (phase_q < (bit_val ? T1H_P : T0H_P));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      phase_q  <= '0;
    end else begin
      active_q <= active_d;
      phase_q  <= phase_d;
    end
  end

endmodule

// File: rtl/neopix_frame_serializer.sv
// neopix_frame_serializer: fetches one 24-bit GRB word per LED from the
// frame-buffer RAM and shifts it MSB-first onto the WS2812 line, with a
// latch gap between frames (used upstream as the bank-swap window).
//   clk, rst    : clock, asynchronous active-high reset.
//   led_count   : live LED count, sampled when leaving the latch gap.
//   pix_data    : RAM read data, valid RD_LATENCY cycles after data_req.
//   addr        : LED index being fetched/sent.
//   data_req    : one-cycle read request for addr.
//   reset_state : high for the whole latch gap.
//   frame_done  : one-cycle pulse on entering the latch gap after the last LED.
//   DO          : WS2812 data line.
module neopix_frame_serializer
  import neopix_pkg::*;
#(
  parameter int NUM_LEDS     = DEF_NUM_LEDS,
  parameter int SYSTEM_CLOCK = DEF_SYSTEM_CLOCK,
  parameter int T0H_NS       = DEF_T0H_NS,
  parameter int T1H_NS       = DEF_T1H_NS,
  parameter int BIT_NS       = DEF_BIT_NS,
  parameter int RESET_US     = DEF_RESET_US,
  parameter int RD_LATENCY   = DEF_RD_LATENCY
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [$clog2(NUM_LEDS):0]   led_count,
  input  logic [23:0]                 pix_data,
  output logic [$clog2(NUM_LEDS)-1:0] addr,
  output logic                        data_req,
  output logic                        reset_state,
  output logic                        frame_done,
  output logic                        DO
);

  localparam int T0H_C   = cycles_from_ns(SYSTEM_CLOCK, T0H_NS);
  localparam int T1H_C   = cycles_from_ns(SYSTEM_CLOCK, T1H_NS);
  localparam int BIT_C   = cycles_from_ns(SYSTEM_CLOCK, BIT_NS);
  localparam int RESET_C = cycles_from_ns(SYSTEM_CLOCK, RESET_US * 1000);

  localparam int AW = $clog2(NUM_LEDS);
  localparam int LW = (RESET_C > 1) ? $clog2(RESET_C) : 1;
  localparam int WW = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;

  localparam logic [LW-1:0] LATCH_LAST = LW'(RESET_C - 1);
  localparam logic [WW-1:0] RD_LAST    = WW'(RD_LATENCY);
  localparam logic [AW-1:0] ADDR_LAST  = AW'(NUM_LEDS - 1);
  localparam logic [AW:0]   NUM_LEDS_P = (AW + 1)'(NUM_LEDS);

  generate
    if (T1H_C >= BIT_C || T0H_C == 0) begin : g_bad_timing
      $error("neopix_frame_serializer: need 0 < T0H and T1H < BIT (in cycles)");
    end
  endgenerate

  state_e        state_q, state_d;
  logic [LW-1:0] latch_cnt_q, latch_cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [23:0]   shift_q, shift_d;
  logic [4:0]    bit_idx_q, bit_idx_d;
  logic          frame_done_q, frame_done_d;
  logic          timer_start, bit_done, timer_do;

  always_comb begin
    state_d      = state_q;
    latch_cnt_d  = latch_cnt_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    wait_d       = wait_q;
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    frame_done_d = 1'b0;
    timer_start  = 1'b0;
    case (state_q)
      LATCH: begin
        latch_cnt_d = latch_cnt_q + 1'b1;
        if (latch_cnt_q == LATCH_LAST) begin
          state_d = FETCH;
          addr_d  = '0;
          wait_d  = '0;
          cnt_d   = (led_count > NUM_LEDS_P) ? NUM_LEDS_P : led_count;
        end
      end
      FETCH: begin
        wait_d = wait_q + 1'b1;
        // pix_data is only trusted on this one cycle; LEDs past the live
        // count are blanked here so SEND never needs to know about them.
        if (wait_q == RD_LAST) begin
          shift_d     = ({1'b0, addr_q} < cnt_q) ? pix_data : 24'h0;
          bit_idx_d   = 5'd23;
          state_d     = SEND;
          timer_start = 1'b1;
        end
      end
      SEND: begin
        if (bit_done) begin
          shift_d   = {shift_q[22:0], 1'b0};
          bit_idx_d = bit_idx_q - 1'b1;
          if (bit_idx_q == 5'd0) begin
            if (addr_q == ADDR_LAST) begin
              frame_done_d = 1'b1;
              state_d      = LATCH;
              latch_cnt_d  = '0;
            end else begin
              addr_d  = addr_q + 1'b1;
              wait_d  = '0;
              state_d = FETCH;
            end
          end else begin
            timer_start = 1'b1;
          end
        end
      end
      default: begin
        state_d     = LATCH;
        latch_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LATCH;
      latch_cnt_q  <= '0;
      addr_q       <= '0;
      cnt_q        <= '0;
      wait_q       <= '0;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      latch_cnt_q  <= latch_cnt_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      wait_q       <= wait_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      frame_done_q <= frame_done_d;
    end
  end

  neopix_bit_timer #(
    .T0H (T0H_C),
    .T1H (T1H_C),
    .BIT (BIT_C)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .start    (timer_start),
    .bit_val  (shift_q[23]),
    .do_out   (timer_do),
    .bit_done (bit_done)
  );

  assign addr        = addr_q;
  assign data_req    = (state_q == FETCH) && (wait_q == '0);
  assign reset_state = (state_q == LATCH);
  assign frame_done  = frame_done_q;
  assign DO          = timer_do && (state_q == SEND);

endmodule

// File: tb/tb_neopix_frame_serializer.sv
// Bench for neopix_frame_serializer: a RAM model answers data_req exactly
// two cycles later (garbage otherwise), pushes the expected pixel into a
// scoreboard, and a line decoder pops and compares each received pixel.
module tb_neopix_frame_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  led_count = 4'd8;
  logic [23:0] pix_data = 24'h0;
  logic [2:0]  addr;
  logic        data_req, reset_state, frame_done, do_line;

  neopix_frame_serializer dut (
    .clk         (clk),
    .rst         (rst),
    .led_count   (led_count),
    .pix_data    (pix_data),
    .addr        (addr),
    .data_req    (data_req),
    .reset_state (reset_state),
    .frame_done  (frame_done),
    .DO          (do_line)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [23:0] mem [8];
  logic [23:0] exp_q[$];
  int          lc_model = 8;
  int          pix_in_frame = 0;
  int          pix_total = 0;
  int          frames_done = 0;

  // RAM model, scoreboard producer and line decoder, all sampled on negedge.
  initial begin
    logic        d1_v, d2_v, prev_req, prev_fd;
    logic [23:0] d1_val, d2_val, cur;
    logic [2:0]  exp_addr;
    int          hi, nbits;
    d1_v = 0; d2_v = 0; prev_req = 0; prev_fd = 0;
    d1_val = 0; d2_val = 0; cur = 0; exp_addr = 0; hi = 0; nbits = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        d1_v = 0; d2_v = 0; prev_req = 0; prev_fd = 0;
        exp_addr = 0; hi = 0; nbits = 0; pix_in_frame = 0;
        exp_q.delete();
        pix_data = 24'($urandom);
      end else begin
        if (reset_state) lc_model = (led_count > 4'd8) ? 8 : int'(led_count);
        if (data_req) begin
          chk("req_pulse", 32'(prev_req), 32'd0);
          chk("req_addr", 32'(addr), 32'(exp_addr));
          exp_addr = exp_addr + 3'd1;
          exp_q.push_back((int'(addr) < lc_model) ? mem[addr] : 24'h0);
        end
        prev_req = data_req;
        // valid only in the cycle two after data_req
        pix_data = d2_v ? d2_val : 24'($urandom);
        d2_v = d1_v; d2_val = d1_val;
        d1_v = data_req; d1_val = mem[addr];
        if (do_line) begin
          hi++;
        end else if (hi > 0) begin
          if (hi != 40 && hi != 20) chk("bit_high", 32'(hi), (hi > 30) ? 32'd40 : 32'd20);
          cur = {cur[22:0], (hi > 30)};
          hi = 0;
          nbits++;
          if (nbits == 24) begin
            nbits = 0;
            pix_in_frame++;
            pix_total++;
            if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
            else chk("pixel", 32'(cur), 32'(exp_q.pop_front()));
            $display("[TB] pixel %0d received %h", pix_total, cur);
          end
        end
        if (frame_done) begin
          chk("fd_pulse", 32'(prev_fd), 32'd0);
          chk("frame_pix", 32'(pix_in_frame), 32'd8);
          chk("frame_sb", 32'(exp_q.size()), 32'd0);
          pix_in_frame = 0;
          frames_done++;
          exp_addr = 0;
        end
        prev_fd = frame_done;
      end
    end
  end

  task automatic measure_gap(input string tag);
    int cnt, dohi;
    cnt = 0; dohi = 0;
    while (reset_state === 1'b1 && cnt < 5000) begin
      cnt++;
      if (do_line) dohi++;
      @(negedge clk);
    end
    chk({tag, "_len"}, 32'(cnt), 32'd3000);
    chk({tag, "_do"}, 32'(dohi), 32'd0);
    chk({tag, "_req"}, 32'(data_req), 32'd1);
    chk({tag, "_addr"}, 32'(addr), 32'd0);
  endtask

  task automatic wait_frame_done();
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < 20000) begin
      n++;
      @(negedge clk);
    end
    chk("fd_seen", 32'(frame_done), 32'd1);
  endtask

  task automatic wait_req_addr(input logic [2:0] a);
    int n;
    n = 0;
    while (!(data_req === 1'b1 && addr === a) && n < 20000) begin
      n++;
      @(negedge clk);
    end
    chk("req_wait", 32'(addr), 32'(a));
  endtask

  initial begin
    int hi, lo, n, p0;
    for (int i = 0; i < 8; i++) mem[i] = 24'h0;
    mem[0] = 24'hFF0000;
    repeat (3) @(negedge clk);
    chk("rst_do", 32'(do_line), 32'd0);
    chk("rst_rs", 32'(reset_state), 32'd1);
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    measure_gap("gap0");

    // LED0 = FF0000: 8 long pulses then 16 short ones; last low includes fetch gap
    for (int b = 0; b < 24; b++) begin
      n = 0;
      while (do_line !== 1'b1 && n < 200) begin n++; @(negedge clk); end
      hi = 0;
      while (do_line === 1'b1 && hi < 200) begin hi++; @(negedge clk); end
      lo = 0;
      while (do_line === 1'b0 && lo < 200) begin lo++; @(negedge clk); end
      chk($sformatf("wave_hi%0d", b), 32'(hi), (b < 8) ? 32'd40 : 32'd20);
      chk($sformatf("wave_lo%0d", b), 32'(lo), (b == 23) ? 32'd45 : ((b < 8) ? 32'd22 : 32'd42));
    end
    wait_frame_done();

    // frame 2: A5A5A5 everywhere
    for (int i = 0; i < 8; i++) mem[i] = 24'hA5A5A5;
    @(negedge clk);
    wait_frame_done();

    // frame 3: only 3 live LEDs; mid-frame change to 12 must not apply yet
    led_count = 4'd3;
    for (int i = 0; i < 8; i++) mem[i] = 24'hFFFFFF;
    @(negedge clk);
    wait_req_addr(3'd4);
    led_count = 4'd12;
    wait_frame_done();

    // frame 4: count 12 clamps to 8, all white
    @(negedge clk);
    wait_frame_done();
    chk("frames", 32'(frames_done), 32'd4);

    // frame 5: count 0 (all black), reset mid-bit at LED 4
    led_count = 4'd0;
    @(negedge clk);
    wait_req_addr(3'd4);
    n = 0;
    while (do_line !== 1'b1 && n < 200) begin n++; @(negedge clk); end
    repeat (5) @(negedge clk);
    chk("pre_rst_do", 32'(do_line), 32'd1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("mid_rst_do", 32'(do_line), 32'd0);
    chk("mid_rst_addr", 32'(addr), 32'd0);
    chk("mid_rst_rs", 32'(reset_state), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    measure_gap("gap1");
    p0 = pix_total;
    n = 0;
    while (pix_total == p0 && n < 3000) begin n++; @(negedge clk); end
    chk("restart_pix", 32'(pix_total - p0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
